// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: op encoding, requester id and FSM states.
package alu_arb_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef logic req_id_t;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each ALU operation in flight.
module alu_arb_tag_fifo
  import alu_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  req_id_t       din,
  input  logic          pop,
  output req_id_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_id_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_rd];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wr <= r_wr + 1'b1;
      if (w_doPop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared in-order ALU with result routing by tag.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0]            req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_op,
  output logic                  alu_valid,
  input  logic                  alu_ready,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_res_valid,
  output logic                  alu_res_ready,
  output logic [CW-1:0]         outstanding
);

  arb_state_t       r_state;
  arb_state_t       w_nextState;
  req_id_t          r_lock;
  logic [WIDTH-1:0] r_holdA;
  logic [WIDTH-1:0] r_holdB;
  logic             r_holdOp;
  req_id_t          w_grant;
  req_id_t          w_head;
  logic             w_valid;
  logic             w_issue;
  logic             w_pop;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
`ifndef ALU_ARB_FIXED_PRIO_EN
  req_id_t          r_last;
`endif

  // Outputs are forced idle while reset_n is low, even before the first edge.
  always_comb begin
    w_grant     = 1'b0;
    w_valid     = 1'b0;
    w_nextState = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = OP_ADD;
    if (reset_n) begin
      case (r_state)
        ST_ARB: begin
          if (!w_fifoFull && (req_valid != 2'b00)) begin
            w_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_grant = req_valid[1] && !req_valid[0];
`else
            w_grant = (req_valid == 2'b11) ? ~r_last : req_valid[1];
`endif
            alu_a  = req_a[w_grant];
            alu_b  = req_b[w_grant];
            alu_op = req_op[w_grant];
            if (!alu_ready) w_nextState = ST_HOLD;
          end
        end
        ST_HOLD: begin
          w_valid = 1'b1;
          w_grant = r_lock;
          alu_a   = r_holdA;
          alu_b   = r_holdB;
          alu_op  = r_holdOp;
          if (alu_ready) w_nextState = ST_ARB;
        end
        default: w_nextState = ST_ARB;
      endcase
    end
  end

  assign alu_valid = w_valid;
  assign w_issue   = w_valid && alu_ready;
  assign req_ready = w_issue ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  // Operands are captured on a stalled offer so the ALU sees them frozen until accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_ARB;
      r_lock   <= 1'b0;
      r_holdA  <= '0;
      r_holdB  <= '0;
      r_holdOp <= OP_ADD;
    end else begin
      r_state <= w_nextState;
      if ((r_state == ST_ARB) && w_valid && !alu_ready) begin
        r_lock   <= w_grant;
        r_holdA  <= alu_a;
        r_holdB  <= alu_b;
        r_holdOp <= alu_op;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!reset_n)     r_last <= 1'b1;
    else if (w_issue) r_last <= w_grant;
  end
`endif

  assign alu_res_ready = reset_n && !w_fifoEmpty && rsp_ready[w_head];
  assign w_pop         = alu_res_valid && alu_res_ready;
  assign rsp_valid     = (reset_n && alu_res_valid && !w_fifoEmpty) ?
                         (w_head ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result    = alu_result;

  alu_arb_tag_fifo #(.DEPTH(DEPTH)) u_tagFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_issue),
    .din     (w_grant),
    .pop     (w_pop),
    .dout    (w_head),
    .full    (w_fifoFull),
    .empty   (w_fifoEmpty),
    .count   (outstanding)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a 2-cycle in-order ALU stand-in; honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       reqValid = 2'b00;
  logic [1:0]       reqReady;
  logic [1:0][31:0] reqA = '0;
  logic [1:0][31:0] reqB = '0;
  logic [1:0]       reqOp = 2'b00;
  logic [1:0]       rspValid;
  logic [1:0]       rspReady = 2'b00;
  logic [31:0]      rspResult;
  logic [31:0]      aluA, aluB, aluResult;
  logic             aluOp, aluValid, aluReady, aluResValid, aluResReady;
  logic [2:0]       outstanding;
  logic             forceStall = 1'b0;
  int               passCount = 0;
  int               checkCount = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_a(reqA), .req_b(reqB), .req_op(reqOp),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_result(rspResult),
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_valid(aluValid), .alu_ready(aluReady),
    .alu_result(aluResult), .alu_res_valid(aluResValid), .alu_res_ready(aluResReady),
    .outstanding(outstanding)
  );

  // In-order ALU stand-in: results appear two edges after issue, up to 8 buffered.
  logic [31:0] mRes [8];
  int          mRdy [8];
  logic [2:0]  mHead = 3'd0;
  logic [2:0]  mTail = 3'd0;
  logic [3:0]  mCount = 4'd0;
  int          cycle = 0;
  logic        mPush, mPop;

  function automatic logic [31:0] fpModel(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3f800000 && b == 32'h40000000) return op ? 32'h40000000 : 32'h40400000;
    if (a == 32'h40a00000 && b == 32'h40400000) return op ? 32'h41700000 : 32'h41000000;
    return a ^ b;
  endfunction

  assign aluReady    = (mCount < 4'd8) && !forceStall;
  assign aluResValid = (mCount != 4'd0) && (mRdy[mHead] <= cycle);
  assign aluResult   = mRes[mHead];
  assign mPush       = aluValid && aluReady;
  assign mPop        = aluResValid && aluResReady;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!reset_n) begin
      mHead  <= 3'd0;
      mTail  <= 3'd0;
      mCount <= 4'd0;
    end else begin
      if (mPush) begin
        mRes[mTail] <= fpModel(aluA, aluB, aluOp);
        mRdy[mTail] <= cycle + 2;
        mTail       <= mTail + 3'd1;
      end
      if (mPop) mHead <= mHead + 3'd1;
      mCount <= mCount + 4'(mPush) - 4'(mPop);
    end
  end

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy);
    reqValid = valid;
    rspReady = rdy;
  endtask

  task automatic setReq(input int id, input logic [31:0] a, input logic [31:0] b, input logic op);
    reqA[id]  = a;
    reqB[id]  = b;
    reqOp[id] = op;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic waitRsp(input int id, input logic [31:0] exp);
    for (int i = 0; i < 20 && rspValid == 2'b00; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("rspValid", 32'(rspValid), (id == 0) ? 32'd1 : 32'd2);
    checkOutput("rspResult", rspResult, exp);
    @(negedge clk); #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    forceStall = 1'b0;
    applyStimulus(2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset with both requesters asserting: everything must stay idle.
    applyStimulus(2'b11, 2'b11);
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("rstAluValid", 32'(aluValid), 32'd0);
    checkOutput("rstReqReady", 32'(reqReady), 32'd0);
    checkOutput("rstRspValid", 32'(rspValid), 32'd0);
    checkOutput("rstResReady", 32'(aluResReady), 32'd0);
    checkOutput("rstAluA", aluA, 32'd0);
    checkOutput("rstOutstanding", 32'(outstanding), 32'd0);

    // Single requester add: 1.0 + 2.0 = 3.0 to requester 0 only.
    reset_n = 1'b1;
    setReq(0, 32'h3f800000, 32'h40000000, 1'b0);
    applyStimulus(2'b01, 2'b11); #1;
    checkOutput("r0AluValid", 32'(aluValid), 32'd1);
    checkOutput("r0ReqReady", 32'(reqReady), 32'd1);
    checkOutput("r0AluA", aluA, 32'h3f800000);
    @(negedge clk);
    applyStimulus(2'b00, 2'b11); #1;
    checkOutput("r0Outstanding", 32'(outstanding), 32'd1);
    waitRsp(0, 32'h40400000);
    checkOutput("r0NoMoreRsp", 32'(rspValid), 32'd0);
    checkOutput("r0Drained", 32'(outstanding), 32'd0);

    // Contention right after reset: r0 add first, then r1 mul.
    doReset();
    setReq(0, 32'h3f800000, 32'h40000000, 1'b0);
    setReq(1, 32'h3f800000, 32'h40000000, 1'b1);
    applyStimulus(2'b11, 2'b11); #1;
    checkOutput("contFirst", 32'(reqReady), 32'd1);
    checkOutput("contFirstOp", 32'(aluOp), 32'd0);
    @(negedge clk);
    applyStimulus(2'b10, 2'b11); #1;
    checkOutput("contSecond", 32'(reqReady), 32'd2);
    checkOutput("contSecondOp", 32'(aluOp), 32'd1);
    @(negedge clk);
    applyStimulus(2'b00, 2'b11); #1;
    checkOutput("contPeak", 32'(outstanding), 32'd2);
    waitRsp(0, 32'h40400000);
    waitRsp(1, 32'h40000000);

    // Both held valid for six cycles.
    doReset();
    setReq(0, 32'h00000001, 32'h0, 1'b0);
    setReq(1, 32'h00000002, 32'h0, 1'b0);
    applyStimulus(2'b11, 2'b11); #1;
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      checkOutput("grantSeq", 32'(reqReady), 32'd1);
`else
      checkOutput("grantSeq", 32'(reqReady), (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
      @(negedge clk); #1;
    end
    applyStimulus(2'b00, 2'b11);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("grantDrained", 32'(outstanding), 32'd0);

    // Responses stalled: only DEPTH issues fit, no issue on the cycle a pop frees space.
    doReset();
    setReq(0, 32'h3f800000, 32'h40000000, 1'b0);
    applyStimulus(2'b01, 2'b00); #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("fillIssue", 32'(reqReady), 32'd1);
      @(negedge clk); #1;
    end
    checkOutput("fullAluValid", 32'(aluValid), 32'd0);
    checkOutput("fullReqReady", 32'(reqReady), 32'd0);
    checkOutput("fullOutstanding", 32'(outstanding), 32'd4);
    checkOutput("fullRspValid", 32'(rspValid), 32'd1);
    @(negedge clk); #1;
    checkOutput("stillBlocked", 32'(aluValid), 32'd0);
    applyStimulus(2'b01, 2'b01); #1;
    checkOutput("popResReady", 32'(aluResReady), 32'd1);
    checkOutput("popSameCycle", 32'(aluValid), 32'd0);
    @(negedge clk); #1;
    checkOutput("afterPopCount", 32'(outstanding), 32'd3);
    checkOutput("afterPopValid", 32'(aluValid), 32'd1);
    applyStimulus(2'b00, 2'b11);

    // ALU stall holds r1's grant while r0 arrives; then reset mid-flight.
    doReset();
    forceStall = 1'b1;
    setReq(1, 32'h40a00000, 32'h40400000, 1'b1);
    setReq(0, 32'h12345678, 32'h9abcdef0, 1'b0);
    applyStimulus(2'b10, 2'b11); #1;
    checkOutput("stallValid", 32'(aluValid), 32'd1);
    checkOutput("stallReqReady", 32'(reqReady), 32'd0);
    checkOutput("stallAluA", aluA, 32'h40a00000);
    @(negedge clk);
    applyStimulus(2'b11, 2'b11); #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("holdAluA", aluA, 32'h40a00000);
      checkOutput("holdAluOp", 32'(aluOp), 32'd1);
      checkOutput("holdReqReady", 32'(reqReady), 32'd0);
      @(negedge clk); #1;
    end
    forceStall = 1'b0; #1;
    checkOutput("holdRelease", 32'(reqReady), 32'd2);
    checkOutput("holdAluB", aluB, 32'h40400000);
    @(negedge clk);
    applyStimulus(2'b01, 2'b11); #1;
    checkOutput("afterHoldR0", 32'(reqReady), 32'd1);
    @(negedge clk); #1;
    checkOutput("midFlight", 32'(outstanding), 32'd2);
    reset_n = 1'b0;
    applyStimulus(2'b11, 2'b11); #1;
    checkOutput("inRstAluValid", 32'(aluValid), 32'd0);
    checkOutput("inRstRspValid", 32'(rspValid), 32'd0);
    @(negedge clk); #1;
    checkOutput("postRstCount", 32'(outstanding), 32'd0);
    checkOutput("postRstAluValid", 32'(aluValid), 32'd0);
    checkOutput("postRstReqReady", 32'(reqReady), 32'd0);
    checkOutput("postRstRspValid", 32'(rspValid), 32'd0);
    checkOutput("postRstResReady", 32'(aluResReady), 32'd0);
    reset_n = 1'b1;
    applyStimulus(2'b00, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, max ALU operations in flight (tag FIFO depth, power of 2, >=2).
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  [1:0]  per-requester operation valid.
REQ-006 req_ready  output  [1:0]  per-requester operation accepted this cycle.
REQ-007 req_a, req_b  input  [1:0][WIDTH-1:0]  per-requester FP32 operands.
REQ-008 req_op  input  [1:0]  per-requester op: 0 add, 1 mul.
REQ-009 rsp_valid  output  [1:0]  result valid to requester i.
REQ-010 rsp_ready  input  [1:0]  requester i accepts result.
REQ-011 rsp_result  output  WIDTH  shared result bus, meaningful only where rsp_valid set.
REQ-012 alu_a, alu_b  output  WIDTH; alu_op  output  1; alu_valid  output  1  drive ALU_LI a_in/b_in/op_in/valid_in.
REQ-013 alu_ready  input  1  from ALU_LI ready_out.
REQ-014 alu_result  input  WIDTH; alu_res_valid  input  1  from ALU_LI result_out/valid_out.
REQ-015 alu_res_ready  output  1  to ALU_LI ready_in.
REQ-016 outstanding  output  $clog2(DEPTH+1)  ops issued, result not yet delivered.

Function
REQ-017 Issue handshake = alu_valid && alu_ready; response handshake = alu_res_valid && alu_res_ready.
REQ-018 FSM states ARB, HOLD: ARB picks grantee combinationally; ARB->HOLD when alu_valid && !alu_ready; HOLD->ARB on issue handshake.
REQ-019 In HOLD grant, alu_a/alu_b/alu_op frozen to the locked requester; alu_valid stays 1 (no withdrawal, no switching).
REQ-020 In ARB with one requester valid, grant it; both valid, grant the one not last issued (round-robin pointer).
REQ-021 Round-robin pointer updates only on issue handshake; after reset requester 0 wins first contention.
REQ-022 req_ready[i] = 1 only in the cycle of issue handshake for grantee i; zero otherwise.
REQ-023 Issue blocked (alu_valid=0 in ARB) when tag FIFO full, even if a response pops the same cycle.
REQ-024 Each issue pushes grantee id into tag FIFO; ALU_LI returns results in order.
REQ-025 rsp_valid[h] = alu_res_valid && FIFO non-empty, h = FIFO head; other bit 0; rsp_result = alu_result.
REQ-026 alu_res_ready = rsp_ready[h] && FIFO non-empty; response handshake pops FIFO.
REQ-027 Head-of-line: stalled head requester blocks later results for the other requester.
REQ-028 outstanding +1 on issue, -1 on pop, unchanged on both same cycle; never exceeds DEPTH.
REQ-029 alu_res_valid with empty FIFO is a protocol error: alu_res_ready=0, no rsp_valid.

Reset
REQ-030 reset_n low at posedge: state ARB, pointer favours requester 0, FIFO empty, outstanding 0.
REQ-031 During/after reset: alu_valid, alu_res_ready, req_ready, rsp_valid all 0; alu_a/alu_b/alu_op 0.
REQ-032 Reset mid-operation discards in-flight tags; ALU_LI is reset from the same reset_n.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, pointer logic removed.
REQ-034 Macro undefined: round-robin per REQ-020/021.

Structure
REQ-035 Shared package alu_arb_pkg: op encoding (OP_ADD=0, OP_MUL=1), requester-id typedef, FSM state enum.
REQ-036 Sub-module alu_arb_tag_fifo (parameter DEPTH, 1-bit data, push/pop/full/empty/count) holds tags.

Verification
REQ-037 Bench instantiates alu_arbiter with ALU_LI (ADD_S=2, MUL_S=2), WIDTH=32, DEPTH=4.
REQ-038 r0 only, add 3f800000+40000000 -> rsp_valid[0] with 40400000, rsp_valid[1] never set.
REQ-039 r0 and r1 both valid same cycle after reset, r0 add, r1 mul 3f800000*40000000 -> r0 issued first, results 40400000 to r0 then 40000000 to r1; outstanding peaks 2.
REQ-040 Both held valid 6 cycles -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN all grants to 0.
REQ-041 rsp_ready=0 on both, 5 issues attempted -> exactly 4 issued, outstanding=4, alu_valid low until a pop.
REQ-042 alu_ready forced 0 for 3 cycles during r1 request while r0 raises valid -> grant stays r1, operands stable; reset_n low mid-flight -> outstanding 0, all valids 0 next cycle.
